// File: rtl/mul_client_pkg.sv
// Shared types and defaults for the multiplier dot-product client.
// FSM state encoding, default widths and the saturation constant.
package mul_client_pkg;

  localparam int DATA_W_DEF    = 32;
  localparam int LEN_W_DEF     = 16;
  localparam int ACC_W_DEF     = 80;
  localparam int MAX_OUTST_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [ACC_W_DEF-1:0] ACC_MAX = '1;

endpackage

// File: rtl/mul_outst_ctr.sv
// Up/down counter of multiplier requests in flight.
// Saturates at MAX on increment, never underflows; full when count == MAX.
module mul_outst_ctr
#(
  parameter int MAX = 4,
  parameter int CW  = $clog2(MAX + 1)
)(
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  input  logic          dec,
  output logic          full,
  output logic [CW-1:0] count
);

  localparam logic [CW-1:0] MAXC = CW'(MAX);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          up, dn;

  assign up    = inc & (cnt_q != MAXC);
  assign dn    = dec & (cnt_q != '0);
  assign full  = (cnt_q == MAXC);
  assign count = cnt_q;

  // next count: clear wins, simultaneous up/down cancels
  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (up & ~dn)
      cnt_d = cnt_q + CW'(1);
    else if (dn & ~up)
      cnt_d = cnt_q - CW'(1);
  end

  // count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mul_dotprod_client.sv
// Dot-product initiator on the multiplier val/rdy interface.
// Define DOTPROD_SAT_EN to saturate the accumulator instead of wrapping.
module mul_dotprod_client
  import mul_client_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int LEN_W     = LEN_W_DEF,
  parameter int ACC_W     = ACC_W_DEF,
  parameter int MAX_OUTST = MAX_OUTST_DEF
)(
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_val,
  output logic                cmd_rdy,
  input  logic [LEN_W-1:0]    cmd_len,
  input  logic                opnd_val,
  output logic                opnd_rdy,
  input  logic [DATA_W-1:0]   opnd_a,
  input  logic [DATA_W-1:0]   opnd_b,
  output logic [DATA_W-1:0]   req_msg_a,
  output logic [DATA_W-1:0]   req_msg_b,
  output logic                req_val,
  input  logic                req_rdy,
  input  logic [2*DATA_W-1:0] resp_msg,
  input  logic                resp_val,
  output logic                resp_rdy,
  output logic [ACC_W-1:0]    res_msg,
  output logic                res_val,
  input  logic                res_rdy
);

  localparam int CW = $clog2(MAX_OUTST + 1);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] n_q, n_d;
  logic [LEN_W-1:0] iss_q, iss_d;
  logic [LEN_W-1:0] rcv_q, rcv_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] acc_nx;

  logic          run;
  logic          full;
  logic [CW-1:0] outst;
  logic          can_iss;
  logic          iss_x;
  logic          rsp_x;
  logic          cmd_x;
  logic          res_x;

  assign run     = (state_q == RUN);
  assign can_iss = run & (iss_q < n_q) & ~full;

  assign req_val   = opnd_val & can_iss;
  assign opnd_rdy  = req_rdy & can_iss;
  assign req_msg_a = opnd_a;
  assign req_msg_b = opnd_b;
  assign iss_x     = req_val & req_rdy;

  // a response with nothing in flight cannot belong to us: drop it
  assign resp_rdy = run;
  assign rsp_x    = resp_val & run & (outst != '0);

  assign cmd_rdy = (state_q == IDLE);
  assign cmd_x   = cmd_val & cmd_rdy;
  assign res_val = (state_q == DONE);
  assign res_x   = res_val & res_rdy;
  assign res_msg = acc_q;

`ifdef DOTPROD_SAT_EN
  logic [ACC_W:0] sum;
  assign sum    = {1'b0, acc_q} + (ACC_W+1)'(resp_msg);
  assign acc_nx = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
`else
  assign acc_nx = acc_q + ACC_W'(resp_msg);
`endif

  mul_outst_ctr #(
    .MAX (MAX_OUTST),
    .CW  (CW)
  ) u_outst (
    .clk   (clk),
    .rst   (rst),
    .clr   (cmd_x),
    .inc   (iss_x),
    .dec   (rsp_x),
    .full  (full),
    .count (outst)
  );

  // FSM next state, counters and accumulator update
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    iss_d   = iss_q;
    rcv_d   = rcv_q;
    acc_d   = acc_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_x) begin
          n_d   = cmd_len;
          iss_d = '0;
          rcv_d = '0;
          acc_d = '0;
          state_d = (cmd_len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (iss_x)
          iss_d = iss_q + LEN_W'(1);
        if (rsp_x) begin
          acc_d = acc_nx;
          rcv_d = rcv_q + LEN_W'(1);
          if (rcv_q + LEN_W'(1) == n_q)
            state_d = DONE;
        end
      end
      DONE: begin
        if (res_x)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // state, length, counters and accumulator registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      n_q     <= '0;
      iss_q   <= '0;
      rcv_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      iss_q   <= iss_d;
      rcv_q   <= rcv_d;
      acc_q   <= acc_d;
    end
  end

endmodule

// File: tb/tb_mul_dotprod_client.sv
// Self-checking bench for mul_dotprod_client.
// A queue-based multiplier model and a plain-sum reference give expectations.
module tb_mul_dotprod_client;

  localparam int DW = 32;
  localparam int LW = 16;
  localparam int MO = 4;
`ifdef DOTPROD_SAT_EN
  localparam int AW = 64;
`else
  localparam int AW = 80;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_val;
  logic          cmd_rdy;
  logic [LW-1:0] cmd_len;
  logic          opnd_val;
  logic          opnd_rdy;
  logic [DW-1:0] opnd_a;
  logic [DW-1:0] opnd_b;
  logic [DW-1:0] req_msg_a;
  logic [DW-1:0] req_msg_b;
  logic          req_val;
  logic          req_rdy;
  logic [2*DW-1:0] resp_msg;
  logic          resp_val;
  logic          resp_rdy;
  logic [AW-1:0] res_msg;
  logic          res_val;
  logic          res_rdy;

  always #5 clk = ~clk;

  mul_dotprod_client #(
    .DATA_W    (DW),
    .LEN_W     (LW),
    .ACC_W     (AW),
    .MAX_OUTST (MO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_val   (cmd_val),
    .cmd_rdy   (cmd_rdy),
    .cmd_len   (cmd_len),
    .opnd_val  (opnd_val),
    .opnd_rdy  (opnd_rdy),
    .opnd_a    (opnd_a),
    .opnd_b    (opnd_b),
    .req_msg_a (req_msg_a),
    .req_msg_b (req_msg_b),
    .req_val   (req_val),
    .req_rdy   (req_rdy),
    .resp_msg  (resp_msg),
    .resp_val  (resp_val),
    .resp_rdy  (resp_rdy),
    .res_msg   (res_msg),
    .res_val   (res_val),
    .res_rdy   (res_rdy)
  );

  int checks = 0;
  int errors = 0;

  logic [63:0] pq[$];
  logic [31:0] fa[$];
  logic [31:0] fb[$];
  int nreq, nresp, cyc, last_resp_cyc, max_inflight;
  bit resp_en = 1'b1;
  bit rnd = 1'b0;
  logic [127:0] exp_total;

  function automatic logic [AW-1:0] exp_res();
    logic [127:0] mx;
    mx = (128'd1 << AW) - 128'd1;
`ifdef DOTPROD_SAT_EN
    if (exp_total > mx)
      return '1;
`endif
    return AW'(exp_total & mx);
  endfunction

  // operand source plus in-order multiplier model
  initial begin
    req_rdy  = 1'b0;
    resp_val = 1'b0;
    resp_msg = '0;
    opnd_val = 1'b0;
    opnd_a   = '0;
    opnd_b   = '0;
    cyc      = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pq.delete();
      end else begin
        if (req_val && req_rdy) begin
          checks++;
          if ((req_msg_a !== opnd_a) || (req_msg_b !== opnd_b) ||
              !(opnd_val && opnd_rdy)) begin
            errors++;
            $display("FAIL passthru: req a=%h b=%h, want opnd a=%h b=%h xfer",
                     req_msg_a, req_msg_b, opnd_a, opnd_b);
          end
          pq.push_back(64'(req_msg_a) * 64'(req_msg_b));
          nreq++;
        end
        if (resp_val && resp_rdy) begin
          void'(pq.pop_front());
          nresp++;
          last_resp_cyc = cyc;
        end
        if (opnd_val && opnd_rdy && fa.size() > 0) begin
          void'(fa.pop_front());
          void'(fb.pop_front());
        end
        if (nreq - nresp > max_inflight)
          max_inflight = nreq - nresp;
      end
      @(posedge clk);
      cyc++;
      #1;
      req_rdy  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      resp_val = resp_en && (pq.size() > 0) &&
                 (!rnd || ($urandom_range(0, 2) != 0));
      resp_msg = (pq.size() > 0) ? pq[0] : '0;
      opnd_val = (fa.size() > 0) && (!rnd || ($urandom_range(0, 3) != 0));
      opnd_a   = (fa.size() > 0) ? fa[0] : '0;
      opnd_b   = (fb.size() > 0) ? fb[0] : '0;
    end
  end

  task automatic start_vec();
    exp_total = '0;
  endtask

  task automatic push_op(input logic [31:0] a, input logic [31:0] b);
    fa.push_back(a);
    fb.push_back(b);
    exp_total = exp_total + 128'(a) * 128'(b);
  endtask

  task automatic send_cmd(input int n);
    @(posedge clk);
    #1;
    nreq = 0;
    nresp = 0;
    max_inflight = 0;
    cmd_val = 1'b1;
    cmd_len = LW'(n);
    @(negedge clk);
    checks++;
    if (cmd_rdy !== 1'b1) begin
      errors++;
      $display("FAIL cmd_rdy: got %b want 1", cmd_rdy);
    end
    @(posedge clk);
    #1;
    cmd_val = 1'b0;
  endtask

  task automatic wait_result(input int n, input int hold, input string nm);
    int t;
    bit bad;
    t = 0;
    while (res_val !== 1'b1 && t < 3000) begin
      @(negedge clk);
      if (res_val !== 1'b1)
        t++;
    end
    checks++;
    if (t >= 3000) begin
      errors++;
      $display("FAIL %s timeout: res_val never rose, nresp=%0d want %0d",
               nm, nresp, n);
      return;
    end
    checks++;
    if (n == 0) begin
      if (t !== 0) begin
        errors++;
        $display("FAIL %s latency: res_val after %0d extra cycles want 0", nm, t);
      end
    end else if (cyc !== last_resp_cyc + 1) begin
      errors++;
      $display("FAIL %s latency: res_val at cycle %0d want %0d",
               nm, cyc, last_resp_cyc + 1);
    end
    checks++;
    if (res_msg !== exp_res()) begin
      errors++;
      $display("FAIL %s res_msg: got %h want %h", nm, res_msg, exp_res());
    end
    checks++;
    if (nreq !== n || nresp !== n) begin
      errors++;
      $display("FAIL %s count: reqs=%0d resps=%0d want %0d", nm, nreq, nresp, n);
    end
    checks++;
    if (max_inflight > MO) begin
      errors++;
      $display("FAIL %s inflight: got %0d want <= %0d", nm, max_inflight, MO);
    end
    bad = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      if (res_val !== 1'b1 || res_msg !== exp_res())
        bad = 1'b1;
    end
    if (hold > 0) begin
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL %s hold: val=%b msg=%h want 1 %h",
                 nm, res_val, res_msg, exp_res());
      end
    end
    @(posedge clk);
    #1;
    res_rdy = 1'b1;
    @(posedge clk);
    #1;
    res_rdy = 1'b0;
    @(negedge clk);
    checks++;
    if (cmd_rdy !== 1'b1 || res_val !== 1'b0) begin
      errors++;
      $display("FAIL %s release: cmd_rdy=%b res_val=%b want 1 0",
               nm, cmd_rdy, res_val);
    end
  endtask

  task automatic check_reset_outs(input string nm);
    checks++;
    if (cmd_rdy !== 1'b1 || res_val !== 1'b0 || req_val !== 1'b0 ||
        opnd_rdy !== 1'b0 || resp_rdy !== 1'b0 || res_msg !== '0) begin
      errors++;
      $display("FAIL %s: cmd_rdy=%b res_val=%b req_val=%b opnd_rdy=%b resp_rdy=%b res=%h want 1 0 0 0 0 0",
               nm, cmd_rdy, res_val, req_val, opnd_rdy, resp_rdy, res_msg);
    end
  endtask

  task automatic test_reset();
    #2;
    rst = 1'b1;
    #1;
    check_reset_outs("reset");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_single();
    rnd = 1'b0;
    start_vec();
    push_op(32'd1, 32'd1);
    send_cmd(1);
    wait_result(1, 0, "single");
  endtask

  task automatic test_three();
    start_vec();
    push_op(32'd100, 32'd100);
    push_op(32'd50, 32'd100);
    push_op(32'd12, 32'd30);
    send_cmd(3);
    wait_result(3, 1, "three");
  endtask

  task automatic test_max();
    start_vec();
    push_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    push_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    send_cmd(2);
    wait_result(2, 0, "max_ops");
  endtask

  task automatic test_backpressure();
    rnd = 1'b0;
    resp_en = 1'b0;
    start_vec();
    for (int i = 0; i < 8; i++)
      push_op($urandom, $urandom);
    send_cmd(8);
    repeat (20) @(negedge clk);
    checks++;
    if (nreq !== MO) begin
      errors++;
      $display("FAIL stall reqs: got %0d want %0d", nreq, MO);
    end
    checks++;
    if (opnd_rdy !== 1'b0 || req_val !== 1'b0) begin
      errors++;
      $display("FAIL stall rdy: opnd_rdy=%b req_val=%b want 0 0",
               opnd_rdy, req_val);
    end
    @(posedge clk);
    #1;
    resp_en = 1'b1;
    wait_result(8, 0, "stall");
  endtask

  task automatic test_zero_len();
    start_vec();
    send_cmd(0);
    wait_result(0, 5, "zero_len");
  endtask

  task automatic test_rst_mid();
    int t;
    rnd = 1'b0;
    resp_en = 1'b1;
    start_vec();
    for (int i = 0; i < 4; i++)
      push_op($urandom, $urandom);
    send_cmd(4);
    t = 0;
    while (nresp < 2 && t < 200) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (nresp < 2) begin
      errors++;
      $display("FAIL rst_mid wait: resps=%0d want >= 2", nresp);
    end
    rst = 1'b1;
    #1;
    check_reset_outs("rst_mid");
    fa.delete();
    fb.delete();
    pq.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_outs("rst_mid_after");
    start_vec();
    push_op(32'd256, 32'd16);
    send_cmd(1);
    wait_result(1, 0, "post_rst");
  endtask

  task automatic test_random();
    int n;
    rnd = 1'b1;
    for (int k = 0; k < 8; k++) begin
      n = $urandom_range(1, 10);
      start_vec();
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 4) == 0)
          push_op(32'hFFFF_FFFF, $urandom);
        else
          push_op($urandom, $urandom);
      end
      send_cmd(n);
      wait_result(n, $urandom_range(0, 3), "random");
    end
    rnd = 1'b0;
  endtask

  task automatic test_sat();
    start_vec();
    push_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    push_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    send_cmd(2);
    wait_result(2, 2, "sat");
  endtask

  initial begin
    rst = 1'b0;
    cmd_val = 1'b0;
    cmd_len = '0;
    res_rdy = 1'b0;
    nreq = 0;
    nresp = 0;
    last_resp_cyc = 0;
    max_inflight = 0;
    exp_total = '0;
    test_reset();
    test_single();
    test_three();
    test_max();
    test_backpressure();
    test_zero_len();
    test_rst_mid();
    test_random();
    test_sat();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
